intersection_scheduler: RTL
===========================

// Module: intersection_scheduler
// PURPOSE
//  Sequences right-of-way between the North-South and East-West approaches of one intersection.
//  Drives both 4-bit light vectors; each bit maps to a lamp: [3] left, [2] green, [1] yellow, [0] red.
//  Provides per-direction emergency preemption with yellow and all-red clearance.
//  Guarantees NS and EW never show left or green at the same time.
// PARAMETERS
//  LEFT_CYC   5  cycles of protected left (+red) per direction
//  GREEN_CYC  10 cycles of green per direction
//  YEL_CYC    3  cycles of yellow
//  ALLRED_CYC 2  cycles of all-red clearance between directions
//  WALK_CYC   8  cycles of pedestrian walk (PED_WALK_EN only)
//  CNT_W      5  phase counter width; must hold max(*_CYC)-1
// PORTS
//  clk       in  1  rising-edge clock
//  rst_n     in  1  asynchronous active-low reset
//  emerg_ns  in  1  emergency vehicle on NS approach (level)
//  emerg_ew  in  1  emergency vehicle on EW approach (level)
//  ns_light  out 4  NS lamps: 1001 left, 0100 green, 0010 yellow, 0001 red
//  ew_light  out 4  EW lamps, same encoding
//  phase     out 4  current phase code (debug/monitor)
//  preempt   out 1  high while in any preemption phase
//  ped_req   in  1  pedestrian button, one-cycle pulse (PED_WALK_EN only)
//  walk      out 1  walk lamp (PED_WALK_EN only)
// BEHAVIOUR
//  - Reset: phase=AR_B, cnt=0, ns_light=ew_light=0001, preempt=0, walk=0, ped latch=0.
//  - Lights, phase, preempt and walk are a pure decode of the phase register (Moore).
//    They change on the same clk edge as the phase.
//  - Normal cycle: NS_LEFT -> NS_GRN -> NS_YEL -> AR_A -> EW_LEFT -> EW_GRN -> EW_YEL -> AR_B -> NS_LEFT.
//  - Phase length: cnt counts 0..N-1 in each phase, where N is that phase's *_CYC.
//    At cnt==N-1 the phase advances and cnt returns to 0.
//    Full period = 2*(5+10+3+2) = 40 cycles.
//  - Opposing lamp is 0001 in every phase except its own LEFT/GRN/YEL.
//  - emerg_* are registered once before use, so the FSM reacts 1 cycle after the input.
//  - Both emergencies asserted at once: NS wins. EW is served after NS releases.
//  - Emergency for direction D while D is in LEFT or GRN:
//      enter PRE_D_HOLD (D green 0100, opposing 0001); cnt frozen.
//  - Emergency for D while the opposing direction is in LEFT or GRN:
//      go to the opposing YEL with cnt=0, then AR, then PRE_D_HOLD.
//  - Emergency for D while in a YEL or AR phase:
//      that phase completes normally, then go to PRE_D_HOLD instead of the next phase.
//  - PRE_D_HOLD lasts while the registered emerg_D=1.
//    On release: D_YEL (cnt=0), then the normal sequence resumes with the AR that follows D_YEL.
//  - The emergency for the other direction, seen during PRE_D_HOLD, waits for release.
//    It is then served through D_YEL -> AR -> PRE_other_HOLD.
//  - rst_n low mid-phase or mid-preemption: immediate return to reset values; no clearance is owed.
//  - Safety assertion (bench and RTL `ifdef SIM`): never (ns_light[3]|ns_light[2]) & (ew_light[3]|ew_light[2]).
// CONFIGURATION
//  - PED_WALK_EN defined:
//      ped_req sets a sticky latch.
//      At the end of AR_A or AR_B with the latch set, insert phase WALK for WALK_CYC cycles.
//      During WALK: both lights 0001, walk=1.
//      The latch clears on WALK entry; the sequence then continues where it left off.
//      Emergency takes priority: it skips WALK and the latch stays set.
//  - PED_WALK_EN undefined: no ped_req or walk ports, no WALK phase, no latch.
// STRUCTURE
//  - Package intersection_pkg holds:
//      the phase enum (4-bit codes);
//      the lamp constants L_LEFT=4'b1001, L_GRN=4'b0100, L_YEL=4'b0010, L_RED=4'b0001;
//      a function phase_len(phase) returning the *_CYC value.
//  - Sub-module phase_timer (CNT_W):
//      ports load, freeze, len; output done = (cnt==len-1).
//      It is reused by the FSM for every phase.
// TESTING
//  1. Release reset, no inputs, run 80 cycles.
//     Expect ns_light 1001 x5, 0100 x10, 0010 x3, 0001 for the next 22 cycles.
//     Expect the EW mirror offset by 20; the pattern repeats at 40.
//     Exact NS start depends on the reset phase: NS_LEFT begins after 2 cycles of AR_B.
//  2. emerg_ns high during EW_GRN, cycle 3.
//     Expect EW 0010 for 3 cycles, all-red for 2, then NS 0100 with preempt=1.
//     Release: NS 0010 x3, then AR_A, then EW_LEFT.
//  3. emerg_ns and emerg_ew asserted together during AR_B.
//     Expect NS hold first. Release NS: NS_YEL, AR_A, then EW hold.
//  4. emerg_ew pulsed during EW_GRN at cnt=4.
//     Expect hold while asserted, then EW_YEL; total EW green time ≥ 5 cycles.
//  5. rst_n asserted low during a PRE hold.
//     Expect both lights 0001 and preempt=0 immediately, asynchronously.
//  6. (PED_WALK_EN) ped_req pulse during NS_GRN.
//     Expect AR_A, then WALK for 8 cycles with walk=1 and both lights 0001, then EW_LEFT.
//     A second pulse during WALK produces one more WALK at AR_B.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared phase codes, lamp encodings and phase durations for the
// intersection scheduler.
package intersection_pkg;

  localparam int LEFT_CYC   = 5;
  localparam int GREEN_CYC  = 10;
  localparam int YEL_CYC    = 3;
  localparam int ALLRED_CYC = 2;
  localparam int WALK_CYC   = 8;
  localparam int CNT_W      = 5;

  typedef enum logic [3:0] {
    NS_LEFT     = 4'd0,
    NS_GRN      = 4'd1,
    NS_YEL      = 4'd2,
    AR_A        = 4'd3,
    EW_LEFT     = 4'd4,
    EW_GRN      = 4'd5,
    EW_YEL      = 4'd6,
    AR_B        = 4'd7,
    PRE_NS_HOLD = 4'd8,
    PRE_EW_HOLD = 4'd9,
    WALK        = 4'd10
  } phase_e;

  localparam logic [3:0] L_LEFT = 4'b1001;
  localparam logic [3:0] L_GRN  = 4'b0100;
  localparam logic [3:0] L_YEL  = 4'b0010;
  localparam logic [3:0] L_RED  = 4'b0001;

  // Hold phases are untimed; a length of 1 keeps done well defined.
  function automatic logic [CNT_W-1:0] phase_len(
    input phase_e p
  );
    logic [CNT_W-1:0] n;
    case (p)
      NS_LEFT, EW_LEFT: n = CNT_W'(LEFT_CYC);
      NS_GRN,  EW_GRN:  n = CNT_W'(GREEN_CYC);
      NS_YEL,  EW_YEL:  n = CNT_W'(YEL_CYC);
      AR_A,    AR_B:    n = CNT_W'(ALLRED_CYC);
      WALK:             n = CNT_W'(WALK_CYC);
      default:          n = CNT_W'(1);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/intersection_scheduler_timer.sv
// Phase timer shared by every phase of the scheduler FSM:
// restart on load, hold on freeze, done on the last cycle of len.
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             freeze,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == len - CNT_W'(1));

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection scheduler with emergency preemption.
// Optional pedestrian walk phase: define PED_WALK_EN.
module intersection_scheduler
  import intersection_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emerg_ns,
  input  logic       emerg_ew,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [3:0] ns_light,
  output logic [3:0] ew_light,
  output logic [3:0] phase,
  output logic       preempt
);

  phase_e           phase_q;
  phase_e           phase_d;
  logic             em_ns_r;
  logic             em_ew_r;
  logic             load;
  logic             freeze;
  logic             done;
  logic [CNT_W-1:0] len;
  logic             req_ns;
  logic             req_ew;
  logic             req_any;
  phase_e           hold_ph;

`ifdef PED_WALK_EN
  logic             ped_q;
  logic             to_ew_q;
  logic             enter_walk;
`endif

  assign len = phase_len(phase_q);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .freeze (freeze),
    .len    (len),
    .done   (done)
  );

  // NS wins a simultaneous request.
  assign req_ns  = em_ns_r;
  assign req_ew  = em_ew_r & ~em_ns_r;
  assign req_any = em_ns_r | em_ew_r;
  assign hold_ph = em_ns_r ? PRE_NS_HOLD : PRE_EW_HOLD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= AR_B;
      em_ns_r <= 1'b0;
      em_ew_r <= 1'b0;
    end else begin
      phase_q <= phase_d;
      em_ns_r <= emerg_ns;
      em_ew_r <= emerg_ew;
    end
  end

`ifdef PED_WALK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_q   <= 1'b0;
      to_ew_q <= 1'b0;
    end else begin
      ped_q <= (enter_walk ? 1'b0 : ped_q) | ped_req;
      if (enter_walk) begin
        to_ew_q <= (phase_q == AR_A);
      end
    end
  end
`endif

  always_comb begin
    phase_d = phase_q;
    load    = 1'b0;
    freeze  = 1'b0;
`ifdef PED_WALK_EN
    enter_walk = 1'b0;
`endif
    case (phase_q)
      NS_LEFT, NS_GRN: begin
        if (req_ns) begin
          phase_d = PRE_NS_HOLD;
          freeze  = 1'b1;
        end else if (req_ew) begin
          phase_d = NS_YEL;
          load    = 1'b1;
        end else if (done) begin
          phase_d = (phase_q == NS_LEFT) ? NS_GRN : NS_YEL;
          load    = 1'b1;
        end
      end
      EW_LEFT, EW_GRN: begin
        if (req_ew) begin
          phase_d = PRE_EW_HOLD;
          freeze  = 1'b1;
        end else if (req_ns) begin
          phase_d = EW_YEL;
          load    = 1'b1;
        end else if (done) begin
          phase_d = (phase_q == EW_LEFT) ? EW_GRN : EW_YEL;
          load    = 1'b1;
        end
      end
      // Own-direction request may return to green; others need all-red.
      NS_YEL: begin
        if (done) begin
          phase_d = req_ns ? PRE_NS_HOLD : AR_A;
          load    = 1'b1;
        end
      end
      EW_YEL: begin
        if (done) begin
          phase_d = req_ew ? PRE_EW_HOLD : AR_B;
          load    = 1'b1;
        end
      end
      AR_A, AR_B: begin
        if (done) begin
          load = 1'b1;
          if (req_any) begin
            phase_d = hold_ph;
`ifdef PED_WALK_EN
          end else if (ped_q) begin
            phase_d    = WALK;
            enter_walk = 1'b1;
`endif
          end else begin
            phase_d = (phase_q == AR_A) ? EW_LEFT : NS_LEFT;
          end
        end
      end
      PRE_NS_HOLD: begin
        freeze = 1'b1;
        if (!em_ns_r) begin
          phase_d = NS_YEL;
          load    = 1'b1;
          freeze  = 1'b0;
        end
      end
      PRE_EW_HOLD: begin
        freeze = 1'b1;
        if (!em_ew_r) begin
          phase_d = EW_YEL;
          load    = 1'b1;
          freeze  = 1'b0;
        end
      end
`ifdef PED_WALK_EN
      // Both approaches are red here, so preemption may start at once.
      WALK: begin
        if (req_any) begin
          phase_d = hold_ph;
          load    = 1'b1;
        end else if (done) begin
          phase_d = to_ew_q ? EW_LEFT : NS_LEFT;
          load    = 1'b1;
        end
      end
`endif
      default: begin
        phase_d = AR_B;
        load    = 1'b1;
      end
    endcase
  end

  assign phase = phase_q;

  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    preempt  = 1'b0;
`ifdef PED_WALK_EN
    walk     = 1'b0;
`endif
    unique case (phase_q)
      NS_LEFT: ns_light = L_LEFT;
      NS_GRN:  ns_light = L_GRN;
      NS_YEL:  ns_light = L_YEL;
      EW_LEFT: ew_light = L_LEFT;
      EW_GRN:  ew_light = L_GRN;
      EW_YEL:  ew_light = L_YEL;
      PRE_NS_HOLD: begin
        ns_light = L_GRN;
        preempt  = 1'b1;
      end
      PRE_EW_HOLD: begin
        ew_light = L_GRN;
        preempt  = 1'b1;
      end
`ifdef PED_WALK_EN
      WALK: walk = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef SIM
  always @(posedge clk) begin
    assert (!((ns_light[3] | ns_light[2]) &&
              (ew_light[3] | ew_light[2])));
  end
`endif

endmodule
